// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, s, co, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - wide add sequenced through one shared 4-bit ripple adder
module fa4 (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < 4; i++) begin
            s_o[i]   = x_i[i] ^ y_i[i] ^ c[i];
            c[i+1]   = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
        end
        c_o = c[4];
    end
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    nibble_serial_add_ctrl_if.slave         bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       fa_s;
    logic             fa_co;

    fa4 fa4_inst (
        .x_i (a_sh_q[3:0]),
        .y_i (b_sh_q[3:0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    carry_d = bus.ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[{cnt_q, 2'b00} +: 4] = fa_s;
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // fa_s[3] is the final sum MSB on the last nibble
                    co_d    = fa_co;
                    ovf_d   = (a_msb_q == b_msb_q) && (fa_s[3] != a_msb_q);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed bench with cycle-level result model for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int n_cons = 0;
    bit cmp_en = 1'b0;

    // model: an op is pending for NIB edges after accept, then its result is held until consumed
    int               m_left = 0;
    bit               m_have = 1'b0;
    logic [WIDTH-1:0] m_s    = '0;
    logic             m_co   = 1'b0;
    logic             m_ovf  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [WIDTH:0] sum;
        if (bus.out_valid && bus.out_ready && !rst) n_cons++;
        if (rst) begin
            m_left = 0;
            m_have = 1'b0;
        end else if (m_have) begin
            if (bus.out_ready) m_have = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_have = 1'b1;
        end else if (bus.in_valid) begin
            sum    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.ci};
            m_s    = sum[WIDTH-1:0];
            m_co   = sum[WIDTH];
            m_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            m_left = NIB;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_in_ready", bus.in_ready, (!m_have && m_left == 0 && !rst));
            chk("m_busy", bus.busy, (m_left > 0));
            chk("m_out_valid", bus.out_valid, m_have);
            if (m_have) begin
                chk("m_s", bus.s, m_s);
                chk("m_co", bus.co, m_co);
                chk("m_ovf", bus.ovf, m_ovf);
            end
        end
    end

    task automatic accept(input logic [15:0] ta, input logic [15:0] tb_, input logic tci);
        int guard;
        bus.a = ta; bus.b = tb_; bus.ci = tci; bus.in_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.in_ready && guard < 30);
        if (guard >= 30) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                          input logic [15:0] es, input logic eco, input logic eovf);
        int lat;
        accept(ta, tb_, tci);
        wait_out(lat);
        chk("latency", lat, NIB);
        chk("lit_s", bus.s, es);
        chk("lit_co", bus.co, eco);
        chk("lit_ovf", bus.ovf, eovf);
        @(posedge clk); #1;
        chk("in_ready_after", bus.in_ready, 1);
    endtask

    initial begin
        int lat;
        int cons0;
        logic [15:0] hs;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_s", bus.s, 0);
        chk("rst_co", bus.co, 0);
        chk("rst_ovf", bus.ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        bus.out_ready = 1'b0;
        cons0 = n_cons;
        accept(16'h9000, 16'h9000, 1'b0);
        wait_out(lat);
        chk("bp_latency", lat, NIB);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = ~bus.in_valid;
            hs = 16'($urandom);
            bus.a = hs; bus.b = ~hs; bus.ci = hs[0];
            @(negedge clk);
            chk("bp_s", bus.s, 16'h2000);
            chk("bp_co", bus.co, 1);
            chk("bp_ovf", bus.ovf, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", bus.out_valid, 0);
        chk("bp_consumed", n_cons - cons0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_extra", n_cons - cons0, 1);

        accept(16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_s", bus.s, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
